// File: rtl/timer_pkg.sv
// timer_pkg: shared constants, types and helpers for the tick-delay element.
//   TIMER_MAX_DELAY_DEFAULT   : default longest delay in cycles
//   TIMER_RESET_DELAY_DEFAULT : default delay applied after reset
//   delay_t                   : delay/count field at the default size
//   clamp_delay(value, max)   : maps a raw delay request onto 1..max
package timer_pkg;

  localparam int unsigned TIMER_MAX_DELAY_DEFAULT   = 16;
  localparam int unsigned TIMER_RESET_DELAY_DEFAULT = 4;
  localparam int unsigned TIMER_DW = $clog2(TIMER_MAX_DELAY_DEFAULT + 1);

  typedef logic [TIMER_DW-1:0] delay_t;

  // A zero request would mean "no delay", which the line cannot express,
  // so it is promoted to the shortest real delay of one cycle.
  function automatic int unsigned clamp_delay(input int unsigned value,
                                              input int unsigned max_delay);
    if (value == 0) return 1;
    if (value > max_delay) return max_delay;
    return value;
  endfunction

endpackage

// File: rtl/delay_timer.sv
// delay_timer: runtime-configurable tick-delay line. Every sampled
// timer_input level reappears on timer_output exactly delay_active cycles
// later. A new delay is only adopted while the line is empty (or on a
// clear), so pulses already in flight keep the delay they entered with.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   timer_input  in   level to delay, sampled every rising edge
//   delay_cfg    in   requested delay (0 -> 1, >MAX_DELAY -> MAX_DELAY)
//   clear        in   synchronous flush of every in-flight bit
//   timer_output out  delayed level, tap of the shift register
//   busy         out  at least one 1-bit in the line (incl. timer_output)
//   delay_active out  delay currently applied
//   in_flight    out  number of 1-bits inside the active window
module delay_timer
  import timer_pkg::*;
#(
  parameter int unsigned MAX_DELAY   = TIMER_MAX_DELAY_DEFAULT,
  parameter int unsigned RESET_DELAY = TIMER_RESET_DELAY_DEFAULT,
  parameter int unsigned DW          = $clog2(MAX_DELAY + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          timer_input,
  input  logic [DW-1:0] delay_cfg,
  input  logic          clear,
  output logic          timer_output,
  output logic          busy,
  output logic [DW-1:0] delay_active,
  output logic [DW-1:0] in_flight
);

  logic [MAX_DELAY-1:0] sr;
  logic [MAX_DELAY-1:0] sr_next;
  logic [DW-1:0]        d_req;
  logic [DW-1:0]        in_flight_next;
  logic                 tap;
  logic                 accept;
  logic                 apply_delay;

  assign d_req = DW'(clamp_delay(32'(delay_cfg), MAX_DELAY));

  // Output tap is the last position of the active window, sr[D-1].
  always_comb begin
    tap = 1'b0;
    for (int i = 0; i < int'(MAX_DELAY); i++) begin
      if (DW'(i + 1) == delay_active) tap = sr[i];
    end
  end

  // Shift inside the window only; positions at or beyond D stay zero so a
  // later, longer delay never exposes stale bits.
  always_comb begin
    sr_next = '0;
    if (!clear) begin
      sr_next[0] = timer_input;
      for (int i = 1; i < int'(MAX_DELAY); i++) begin
        if (DW'(i) < delay_active) sr_next[i] = sr[i-1];
      end
    end
  end

  assign accept = timer_input & ~clear;

  // One bit enters at sr[0] and one may leave from the tap; both together
  // leave the count unchanged.
  always_comb begin
    if (clear) in_flight_next = '0;
    else       in_flight_next = in_flight + DW'(accept) - DW'(tap);
  end

  // The delay may only change while nothing is in flight; a clear empties
  // the line on the same edge, so the change can ride along with it.
  assign apply_delay = (in_flight == '0) || clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr           <= '0;
      in_flight    <= '0;
      delay_active <= DW'(RESET_DELAY);
    end else begin
      sr        <= sr_next;
      in_flight <= in_flight_next;
      if (apply_delay) delay_active <= d_req;
    end
  end

  assign timer_output = tap;
  assign busy         = (in_flight != '0);

endmodule

// File: tb/tb_delay_timer.sv
// tb_delay_timer: directed and randomized stimulus for delay_timer, checked
// against a pulse-schedule reference model. Each accepted 1 is recorded as
// the edge index after which it must be visible on timer_output.
module tb_delay_timer;

  localparam int unsigned MAXD = 16;
  localparam int          RSTD = 4;
  localparam int          DW   = $clog2(MAXD + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          timer_input = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] delay_cfg = DW'(4);
  logic          timer_output;
  logic          busy;
  logic [DW-1:0] delay_active;
  logic [DW-1:0] in_flight;

  int checks = 0;
  int errors = 0;
  int k = 0;          // index of the last rising edge seen by the model
  int q[$];           // emit edges of pulses still in the line
  int m_dact = RSTD;  // model's active delay

  delay_timer #(.MAX_DELAY(MAXD), .RESET_DELAY(RSTD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .timer_input  (timer_input),
    .delay_cfg    (delay_cfg),
    .clear        (clear),
    .timer_output (timer_output),
    .busy         (busy),
    .delay_active (delay_active),
    .in_flight    (in_flight)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, k);
    end
  endtask

  function automatic int cnt_ge(input int e);
    int n = 0;
    foreach (q[i]) if (q[i] >= e) n++;
    return n;
  endfunction

  function automatic int dreq(input int cfg);
    if (cfg == 0) return 1;
    if (cfg > int'(MAXD)) return int'(MAXD);
    return cfg;
  endfunction

  task automatic check_all();
    int exp_out;
    int exp_inf;
    exp_out = 0;
    foreach (q[i]) if (q[i] == k) exp_out = 1;
    exp_inf = cnt_ge(k);
    chk("timer_output", 32'(timer_output), 32'(exp_out));
    chk("busy", 32'(busy), 32'(exp_inf != 0));
    chk("in_flight", 32'(in_flight), 32'(exp_inf));
    chk("delay_active", 32'(delay_active), 32'(m_dact));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, check.
  task automatic step(input logic inp, input int cfg, input logic clr);
    int pre;
    timer_input = inp;
    delay_cfg   = DW'(cfg);
    clear       = clr;
    @(posedge clk);
    pre = cnt_ge(k);
    k++;
    if (clr || pre == 0) m_dact = dreq(cfg);
    if (clr) q.delete();
    else if (inp) q.push_back(k + m_dact - 1);
    #1;
    check_all();
    q = q.find(x) with (x >= k);
  endtask

  task automatic idle(input int n, input int cfg);
    for (int i = 0; i < n; i++) step(1'b0, cfg, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_timer_output", 32'(timer_output), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_flight", 32'(in_flight), 32'd0);
    chk("rst_delay_active", 32'(delay_active), 32'(RSTD));
    #2 rst_n = 1'b1;

    // Single pulse at edge 10 with delay 4
    idle(9, 4);
    step(1'b1, 4, 1'b0);
    idle(8, 4);

    // Pattern 1,1,0,1 with delay 3
    idle(2, 3);
    step(1'b1, 3, 1'b0);
    step(1'b1, 3, 1'b0);
    step(1'b0, 3, 1'b0);
    step(1'b1, 3, 1'b0);
    idle(6, 3);

    // Delay change held off while a pulse is in flight
    idle(2, 8);
    step(1'b1, 8, 1'b0);
    step(1'b0, 2, 1'b0);
    chk("held_delay", 32'(delay_active), 32'd8);
    idle(9, 2);
    chk("applied_delay", 32'(delay_active), 32'd2);
    step(1'b1, 2, 1'b0);
    idle(4, 2);

    // Clamping of zero and oversized requests
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    chk("clamp_zero", 32'(delay_active), 32'd1);
    step(1'b1, 0, 1'b0);
    idle(2, 20);
    chk("clamp_max", 32'(delay_active), 32'd16);
    step(1'b1, 20, 1'b0);
    idle(18, 20);

    // Clear with three pulses in flight and a simultaneous input
    idle(2, 6);
    step(1'b1, 6, 1'b0);
    step(1'b0, 6, 1'b0);
    step(1'b1, 6, 1'b0);
    step(1'b0, 6, 1'b0);
    step(1'b1, 6, 1'b0);
    step(1'b1, 6, 1'b1);
    chk("clear_in_flight", 32'(in_flight), 32'd0);
    chk("clear_busy", 32'(busy), 32'd0);
    idle(8, 6);

    // Randomized traffic with occasional delay changes and clears
    begin
      int cfg;
      cfg = 5;
      for (int blk = 0; blk < 6; blk++) begin
        for (int i = 0; i < 80; i++) begin
          if ($urandom_range(0, 99) < 8) cfg = int'($urandom_range(0, 31));
          step(logic'($urandom_range(0, 99) < 30), cfg,
               logic'($urandom_range(0, 99) < 2));
        end
        idle(20, cfg);
      end
    end

    // Asynchronous reset between edges with pulses in flight
    idle(2, 8);
    step(1'b1, 8, 1'b0);
    step(1'b1, 8, 1'b0);
    step(1'b0, 8, 1'b0);
    delay_cfg = DW'(4);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_timer_output", 32'(timer_output), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_in_flight", 32'(in_flight), 32'd0);
    chk("arst_delay_active", 32'(delay_active), 32'(RSTD));
    q.delete();
    m_dact = RSTD;
    repeat (2) @(posedge clk);
    k += 2;
    #2 rst_n = 1'b1;
    idle(20, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
